// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver/transmitter state encoding and default link settings.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_rx_state_e;

    localparam int UART_DEFAULT_BITS         = 8;
    localparam int UART_DEFAULT_CLKS_PER_BIT = 16;

endpackage

// File: rtl/uart_rx_sync.sv
// Multi-flop synchronizer for an asynchronous input; flops reset to 1 (idle level of a UART line).
module uart_rx_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic [SYNC_STAGES-1:0] sync_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/uart_receiver.sv
// 8N1-style UART receiver with mid-bit sampling and LSB-first reassembly.
// Define UART_RX_PARITY_EN to add an even-parity bit and the parity_err output.
module uart_receiver
    import uart_pkg::*;
#(
    parameter int UART_BITS_TRANSFERED = UART_DEFAULT_BITS,
    parameter int CLKS_PER_BIT         = UART_DEFAULT_CLKS_PER_BIT,
    parameter int SYNC_STAGES          = 2
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            rx,
    output logic [UART_BITS_TRANSFERED-1:0] data_out,
    output logic                            valid,
    output logic                            frame_err,
    output logic                            busy
`ifdef UART_RX_PARITY_EN
   ,output logic                            parity_err
`endif
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int BIT_W = $clog2(UART_BITS_TRANSFERED + 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0] LAST_BIT  = BIT_W'(UART_BITS_TRANSFERED - 1);

    uart_rx_state_e state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [BIT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [UART_BITS_TRANSFERED-1:0] shift_q, shift_d, shift_in;
    logic [UART_BITS_TRANSFERED-1:0] data_out_q, data_out_d;
    logic valid_q, valid_d;
    logic frame_err_q, frame_err_d;
    logic rx_s;
    logic half_done, bit_done, stop_sample;
`ifdef UART_RX_PARITY_EN
    logic parity_q, parity_d;
    logic parity_err_q, parity_err_d;
`endif

    uart_rx_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d_i (rx),
        .q_o (rx_s)
    );

    // New bits enter at the MSB so after the last shift bit i sits at index i.
    generate
        if (UART_BITS_TRANSFERED > 1) begin : g_shift_wide
            assign shift_in = {rx_s, shift_q[UART_BITS_TRANSFERED-1:1]};
        end else begin : g_shift_one
            assign shift_in = rx_s;
        end
    endgenerate

    assign half_done = (cnt_q == HALF_LAST);
    assign bit_done  = (cnt_q == FULL_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            data_out_q   <= '0;
            valid_q      <= 1'b0;
            frame_err_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_q     <= 1'b0;
            parity_err_q <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            data_out_q   <= data_out_d;
            valid_q      <= valid_d;
            frame_err_q  <= frame_err_d;
`ifdef UART_RX_PARITY_EN
            parity_q     <= parity_d;
            parity_err_q <= parity_err_d;
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q + CNT_W'(1);
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
`ifdef UART_RX_PARITY_EN
        parity_d  = parity_q;
`endif
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (!rx_s) begin
                    state_d = START;
                end
            end
            START: begin
                // A start bit that is high again at mid-bit was a glitch.
                if (half_done) begin
                    cnt_d     = '0;
                    bit_cnt_d = '0;
                    state_d   = rx_s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (bit_done) begin
                    cnt_d     = '0;
                    shift_d   = shift_in;
                    bit_cnt_d = bit_cnt_q + BIT_W'(1);
                    if (bit_cnt_q == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (bit_done) begin
                    cnt_d    = '0;
                    parity_d = rx_s;
                    state_d  = STOP;
                end
            end
`endif
            STOP: begin
                // Back to IDLE at stop mid-bit so a following start bit is not missed.
                if (bit_done) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        busy         = (state_q != IDLE);
        stop_sample  = (state_q == STOP) && bit_done;
        valid_d      = stop_sample && rx_s;
        frame_err_d  = stop_sample && !rx_s;
        data_out_d   = valid_d ? shift_q : data_out_q;
`ifdef UART_RX_PARITY_EN
        parity_err_d = valid_d && ((^shift_q) ^ parity_q);
`endif
    end

    assign data_out  = data_out_q;
    assign valid     = valid_q;
    assign frame_err = frame_err_q;
`ifdef UART_RX_PARITY_EN
    assign parity_err = parity_err_q;
`endif

endmodule

// File: tb/tb_uart_receiver.sv
// Directed scoreboard bench for uart_receiver; build with UART_RX_PARITY_EN for the parity cases.
module tb_uart_receiver;

    localparam int CPB     = 16;
    localparam int NB      = 8;
    localparam int SS      = 2;
    localparam int EXP_LAT = SS + CPB / 2 + (NB + 1) * CPB;

    logic          clk = 1'b0;
    logic          rst;
    logic          rx;
    logic [NB-1:0] data_out;
    logic          valid;
    logic          frame_err;
    logic          busy;
`ifdef UART_RX_PARITY_EN
    logic          parity_err;
`endif

    uart_receiver #(
        .UART_BITS_TRANSFERED(NB),
        .CLKS_PER_BIT        (CPB),
        .SYNC_STAGES         (SS)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rx        (rx),
        .data_out  (data_out),
        .valid     (valid),
        .frame_err (frame_err),
        .busy      (busy)
`ifdef UART_RX_PARITY_EN
       ,.parity_err(parity_err)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic          is_err;
        logic [NB-1:0] data;
        logic          perr;
    } exp_t;

    exp_t          exp_q[$];
    exp_t          mon_e;
    int            n_assert    = 0;
    int            n_fail      = 0;
    int            cyc         = 0;
    int            fall_cyc    = 0;
    int            lat         = 0;
    logic          lat_arm     = 1'b0;
    int            n_valid_exp = 0;
    int            n_valid_obs = 0;
    logic [NB-1:0] last_good   = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    task automatic send_bit(input logic b);
        rx = b;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic idle_bits(input int n);
        rx = 1'b1;
        repeat (n * CPB) @(negedge clk);
    endtask

    // Expected outcome is queued before the frame goes out on the line.
    task automatic send_frame(input logic [NB-1:0] d, input logic stop_b, input logic par_b);
        exp_t e;
        e.is_err = !stop_b;
        e.data   = d;
        e.perr   = (^d) ^ par_b;
        exp_q.push_back(e);
        if (stop_b) n_valid_exp++;
        $display("tx frame data=0x%02h stop=%0b parity=%0b", d, stop_b, par_b);
        send_bit(1'b0);
        for (int i = 0; i < NB; i++) send_bit(d[i]);
`ifdef UART_RX_PARITY_EN
        send_bit(par_b);
`endif
        send_bit(stop_b);
    endtask

    always @(negedge clk) begin
        if (!rst && (valid || frame_err)) begin
            chk("pulse_exclusive", 32'(valid & frame_err), 32'd0);
            chk("busy_low_at_pulse", 32'(busy), 32'd0);
            chk("event_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                mon_e = exp_q.pop_front();
                chk("event_kind_frame_err", 32'(frame_err), 32'(mon_e.is_err));
                if (mon_e.is_err) begin
                    chk("data_out_held", 32'(data_out), 32'(last_good));
                    $display("rx frame_err data_out=0x%02h", data_out);
                end else begin
                    chk("data_out", 32'(data_out), 32'(mon_e.data));
                    last_good = mon_e.data;
                    n_valid_obs++;
`ifdef UART_RX_PARITY_EN
                    chk("parity_err", 32'(parity_err), 32'(mon_e.perr));
`endif
                    $display("rx valid data_out=0x%02h", data_out);
                end
                if (lat_arm) begin
                    lat = cyc - fall_cyc;
                    chk("latency_in_range", 32'(lat >= EXP_LAT - 1 && lat <= EXP_LAT + 1), 32'd1);
                    lat_arm = 1'b0;
                end
            end
        end
    end

    initial begin
        rst = 1'b1;
        rx  = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_data_out", 32'(data_out), 32'd0);
        chk("reset_valid", 32'(valid), 32'd0);
        chk("reset_frame_err", 32'(frame_err), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        idle_bits(2);

        // Good frame with latency measurement
        fall_cyc = cyc;
        lat_arm  = 1'b1;
        send_frame(8'hA5, 1'b1, ^8'hA5);
        idle_bits(2);

        // Glitch: three cycles low
        chk("glitch_busy_before", 32'(busy), 32'd0);
        rx = 1'b0;
        repeat (3) @(negedge clk);
        rx = 1'b1;
        @(negedge clk);
        chk("glitch_busy_during", 32'(busy), 32'd1);
        repeat (20) @(negedge clk);
        chk("glitch_busy_after", 32'(busy), 32'd0);
        $display("glitch done busy=%0b", busy);
        idle_bits(1);

        // Framing error
        send_frame(8'h3C, 1'b0, ^8'h3C);
        idle_bits(3);

        // Back-to-back frames
        send_frame(8'h00, 1'b1, ^8'h00);
        send_frame(8'hFF, 1'b1, ^8'hFF);
        send_frame(8'h81, 1'b1, ^8'h81);
        idle_bits(2);

        // Reset during data bit 4 of 0x55
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(((8'h55 >> i) & 8'h01) != 0);
        rx = 1'b1;
        repeat (CPB / 2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("midreset_data_out", 32'(data_out), 32'd0);
        chk("midreset_valid", 32'(valid), 32'd0);
        chk("midreset_frame_err", 32'(frame_err), 32'd0);
        chk("midreset_busy", 32'(busy), 32'd0);
        $display("mid-frame reset data_out=0x%02h busy=%0b", data_out, busy);
        last_good = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        idle_bits(2);
        send_frame(8'h12, 1'b1, ^8'h12);
        idle_bits(2);

`ifdef UART_RX_PARITY_EN
        send_frame(8'h07, 1'b1, 1'b0);
        idle_bits(1);
        send_frame(8'h07, 1'b1, 1'b1);
        idle_bits(1);
`endif

        idle_bits(3);
        for (int i = 0; i < 2000 && exp_q.size() != 0; i++) @(negedge clk);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        chk("valid_count", 32'(n_valid_obs), 32'(n_valid_exp));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_receiver.md
Name: uart_receiver

Overview:
Serial-to-parallel UART receive block, the receive end of the team's 8N1 UART link. It samples an asynchronous rx line with a programmable clocks-per-bit divider and mid-bit sampling, then reassembles LSB-first data frames. Each completed frame is presented as a one-cycle valid pulse, and framing errors are flagged. It sits between the board rx pin and the host command/data path feeding the TPU core.

Parameters:
- UART_BITS_TRANSFERED, 8, data bits per frame (1..16).
- CLKS_PER_BIT, 16, clk cycles per serial bit; must be an even number, 4 or more.
- SYNC_STAGES, 2, flops in the rx synchronizer (2 or more).

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-high reset.
- rx  input  1  asynchronous serial line; idles high.
- data_out  output  UART_BITS_TRANSFERED  last good received word.
- valid  output  1  one-cycle pulse: data_out updated this cycle.
- frame_err  output  1  one-cycle pulse: stop bit sampled low.
- busy  output  1  high while a frame is in progress (any state other than IDLE).

Behaviour:
- Reset:
  - state=IDLE; data_out=0, valid=0, frame_err=0, busy=0.
  - Bit counter, sample counter and shift register cleared; synchronizer flops set to 1.
  - Reset asserted mid-frame aborts the frame immediately; no pulses are emitted.
- rx passes through SYNC_STAGES flops; rx_s is the synchronizer output. All decisions use rx_s only.
- States: IDLE, START, DATA, STOP.
- IDLE:
  - Waits for rx_s==0, then goes to START with the sample counter cleared.
- START:
  - Counts CLKS_PER_BIT/2-1 cycles, then samples rx_s at mid-bit.
  - rx_s==1 is a false start (glitch): return to IDLE, no pulse.
  - rx_s==0: go to DATA with counters cleared.
- DATA:
  - Every CLKS_PER_BIT cycles, sample rx_s into the shift register, LSB first (bit i at index i).
  - After UART_BITS_TRANSFERED samples, go to STOP.
- STOP:
  - After CLKS_PER_BIT cycles, sample rx_s.
  - rx_s==1: data_out <= shift register and valid=1 for exactly one cycle.
  - rx_s==0: frame_err=1 for one cycle; data_out is held unchanged.
  - Either way, return to IDLE on the same edge.
- Latency: valid rises on the clk edge after the stop-bit mid-point sample. That is SYNC_STAGES + CLKS_PER_BIT/2 + (UART_BITS_TRANSFERED+1)*CLKS_PER_BIT cycles, ±1, after the rx falling edge.
- Back-to-back frames:
  - IDLE is re-entered at stop mid-bit, so a new start bit arriving right after the stop bit is detected.
  - No idle gap is required beyond the stop bit.
- Line held low after frame_err: IDLE sees rx_s==0 and starts a new frame. This is the defined behaviour (break = repeated frame_err).
- valid and frame_err are never high in the same cycle. There is no backpressure: the consumer must capture on valid.
- Counter widths: $clog2(CLKS_PER_BIT) for the sample counter, $clog2(UART_BITS_TRANSFERED+1) for the bit counter. No wrap occurs within a frame.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - Adds a PARITY state between DATA and STOP, sampled after CLKS_PER_BIT cycles. Even parity: XOR of data bits and parity bit must be 0.
  - Adds output parity_err (1 bit, reset 0). It pulses one cycle alongside valid when parity mismatches; data_out is still updated.
  - If frame_err also applies, only frame_err pulses.
- Undefined: no PARITY state and no parity_err port; frame is exactly start + data + stop.

Decomposition:
- Package uart_pkg holds:
  - typedef enum logic [2:0] uart_rx_state_e (IDLE, START, DATA, PARITY, STOP), shared with a future 3-bit transmitter state encoding.
  - localparam UART_DEFAULT_BITS=8 and UART_DEFAULT_CLKS_PER_BIT=16.
- Sub-module uart_rx_sync: parameterised SYNC_STAGES flop chain with async reset to 1. Reused by other async inputs.

Test Plan:
- Good frame: send 0xA5 with CLKS_PER_BIT=16 (start, 1,0,1,0,0,1,0,1, stop) -> valid pulses once, data_out=0xA5, frame_err=0, busy falls the same cycle.
- Glitch: rx low for 3 cycles then high -> no valid, no frame_err, state back to IDLE, busy high only during the glitch window.
- Framing error: send 0x3C with stop bit 0 -> frame_err pulses once, valid=0, data_out keeps the previous 0xA5.
- Back-to-back: 0x00, 0xFF, 0x81 with no idle gap -> three valid pulses, in order, with the correct values.
- Reset mid-frame: assert rst during data bit 4 of 0x55, then send 0x12 -> outputs zero during reset, no pulse for 0x55, valid with data_out=0x12.
- UART_RX_PARITY_EN: send 0x07 with parity bit 0 (bad) -> valid with data_out=0x07 and parity_err=1. Same byte with parity bit 1 -> parity_err=0.
